axi_mem_arbiter: RTL
====================

Name: axi_mem_arbiter

Overview:
- Sequential AXI-lite arbiter sharing one memory port between two masters: the instruction-fetch master (read-only, I) and the load/store master (read+write, D).
- Locks the memory port per transaction and routes every channel only to the granted master.
- Data has priority, bounded by a starvation limit so fetch always progresses.
- Sits between the CPU core and the memory model.

Parameters:
- MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting before I is forced a grant (1..15).

Ports:
- clk input 1: clock, rising edge.
- rst input 1: asynchronous, active-high reset.
- i_araddr input 32 / i_arvalid input 1 / i_arready output 1: I read address channel.
- i_rdata output 32 / i_rvalid output 1 / i_rready input 1: I read data channel.
- d_araddr input 32 / d_arvalid input 1 / d_arready output 1: D read address channel.
- d_rdata output 32 / d_rvalid output 1 / d_rready input 1: D read data channel.
- d_awaddr input 32 / d_awvalid input 1 / d_awready output 1: D write address channel.
- d_wdata input 32 / d_wstrb input 4 / d_wvalid input 1 / d_wready output 1: D write data channel.
- d_bresp output 2 / d_bvalid output 1 / d_bready input 1: D write response channel.
- m_araddr output 32 / m_arvalid output 1 / m_arready input 1: memory read address channel.
- m_rdata input 32 / m_rvalid input 1 / m_rready output 1: memory read data channel.
- m_awaddr output 32 / m_awvalid output 1 / m_awready input 1: memory write address channel.
- m_wdata output 32 / m_wstrb output 4 / m_wvalid output 1 / m_wready input 1: memory write data channel.
- m_bresp input 2 / m_bvalid input 1 / m_bready output 1: memory write response channel.
- grant output 2: 00 none, 01 I, 10 D read, 11 D write.

Behaviour:
- States: IDLE, I_AR, I_R, D_AR, D_R, D_WR (AW and W pending), D_B. Only state and counters are registered; channel routing is combinational from state.
- Reset: state=IDLE, streak=0, aw_done=w_done=0. Every valid/ready output to master or memory is 0; grant=00; data and address outputs are 0 while ungranted.
- IDLE: no readies asserted; memory valids are 0.
  - d_req = d_arvalid | d_awvalid | d_wvalid.
  - If d_req and (streak < MAX_D_STREAK or !i_arvalid): grant D. Go to D_WR if d_awvalid|d_wvalid, else D_AR. Write beats read if both are pending.
  - Else if i_arvalid: go to I_AR, streak := 0.
  - On a D grant: streak := streak+1 (saturating) if i_arvalid is high that cycle, else streak := 0.
  - Arbitration latency is 1 cycle: a request first seen in IDLE reaches m_* in the next cycle.
- I_AR: m_araddr=i_araddr, m_arvalid=i_arvalid, i_arready=m_arready. On handshake go to I_R.
- I_R: i_rdata=m_rdata, i_rvalid=m_rvalid, m_rready=i_rready. On handshake go to IDLE.
- D_AR/D_R: same as I_AR/I_R but on the d_ channels.
- D_WR: AW and W channels are passed through independently.
  - aw_done and w_done set on their respective handshakes.
  - A channel that is already done has its m_ valid and d_ ready forced to 0.
  - When both are done (same-cycle completion allowed), clear the flags and go to D_B.
- D_B: d_bvalid=m_bvalid, d_bresp=m_bresp, m_bready=d_bready. On handshake go to IDLE.
- No back-to-back grant: IDLE always occupies at least one cycle between transactions.
- Masters must hold valid and payload stable until handshake. A requester dropping valid before grant is simply not granted.
- Ungranted master: all its ready/valid outputs are 0, so no response ever leaks to the wrong master.
- Memory stall of any length: stay in the current state indefinitely; no timeout.
- Async reset mid-transaction: outputs clear immediately. The memory must be reset in the same event; no recovery of in-flight transactions.

Test Plan:
- I only: i_araddr=0x8000_0000, memory returns 0x0000_0413 after 2 cycles -> grant=01; i_rvalid with i_rdata=0x0000_0413; d_rvalid stays 0; back to IDLE.
- Simultaneous i_arvalid and d_arvalid (0x8000_1000) with streak=0 -> D served first (grant=10), I served next; i_rdata is never driven with the D data.
- Write with W 2 cycles before AW (wdata=0xDEAD_BEEF, wstrb=0xF) -> m_wvalid deasserts after W handshake; D_B reached only after AW handshake; d_bresp=00.
- D requesting continuously, I pending, MAX_D_STREAK=4 -> exactly 4 D grants, then grant=01, then streak=0.
- m_rvalid held low for 20 cycles in I_R -> i_rvalid=0 throughout, no new grant; i_rvalid completes on cycle 21.
- rst pulsed in D_WR after the AW handshake -> all m_* valids/readies are 0 that cycle; grant=00; after release a new write completes normally.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// Two-master AXI-lite arbiter: I (fetch, read-only) and D (load/store) share one memory port, 1-cycle arbitration.
// Channels are routed combinationally from state; memory or master stalls hold the current state indefinitely.
module axi_mem_arbiter #(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_araddr,
   input  logic        i_arvalid,
   output logic        i_arready,
   output logic [31:0] i_rdata,
   output logic        i_rvalid,
   input  logic        i_rready,
   input  logic [31:0] d_araddr,
   input  logic        d_arvalid,
   output logic        d_arready,
   output logic [31:0] d_rdata,
   output logic        d_rvalid,
   input  logic        d_rready,
   input  logic [31:0] d_awaddr,
   input  logic        d_awvalid,
   output logic        d_awready,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   input  logic        d_wvalid,
   output logic        d_wready,
   output logic [1:0]  d_bresp,
   output logic        d_bvalid,
   input  logic        d_bready,
   output logic [31:0] m_araddr,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic        m_rvalid,
   output logic        m_rready,
   output logic [31:0] m_awaddr,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready,
   output logic [1:0]  grant
);

   typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_WR, D_B} state_t;

   localparam logic [3:0] STREAK_LIM = 4'(MAX_D_STREAK);

   state_t     state, state_nxt;
   logic [3:0] streak, streak_nxt;
   logic       aw_done, aw_done_nxt;
   logic       w_done, w_done_nxt;
   logic       d_req;
   logic       aw_fin, w_fin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         streak  <= 4'd0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state   <= state_nxt;
         streak  <= streak_nxt;
         aw_done <= aw_done_nxt;
         w_done  <= w_done_nxt;
      end
   end

   assign d_req = d_arvalid | d_awvalid | d_wvalid;

   always_comb begin
      state_nxt   = state;
      streak_nxt  = streak;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      aw_fin      = 1'b0;
      w_fin       = 1'b0;
      grant       = 2'b00;
      i_arready   = 1'b0;
      i_rdata     = 32'd0;
      i_rvalid    = 1'b0;
      d_arready   = 1'b0;
      d_rdata     = 32'd0;
      d_rvalid    = 1'b0;
      d_awready   = 1'b0;
      d_wready    = 1'b0;
      d_bresp     = 2'b00;
      d_bvalid    = 1'b0;
      m_araddr    = 32'd0;
      m_arvalid   = 1'b0;
      m_rready    = 1'b0;
      m_awaddr    = 32'd0;
      m_awvalid   = 1'b0;
      m_wdata     = 32'd0;
      m_wstrb     = 4'd0;
      m_wvalid    = 1'b0;
      m_bready    = 1'b0;

      case (state)
         IDLE: begin
            // D wins unless it has already taken STREAK_LIM grants while I waited
            if (d_req && ((streak < STREAK_LIM) || !i_arvalid)) begin
               state_nxt = (d_awvalid || d_wvalid) ? D_WR : D_AR;
               if (!i_arvalid)
                  streak_nxt = 4'd0;
               else if (streak != 4'hF)
                  streak_nxt = streak + 4'd1;
            end else if (i_arvalid) begin
               state_nxt  = I_AR;
               streak_nxt = 4'd0;
            end
         end
         I_AR: begin
            grant     = 2'b01;
            m_araddr  = i_araddr;
            m_arvalid = i_arvalid;
            i_arready = m_arready;
            if (i_arvalid && m_arready)
               state_nxt = I_R;
         end
         I_R: begin
            grant    = 2'b01;
            i_rdata  = m_rdata;
            i_rvalid = m_rvalid;
            m_rready = i_rready;
            if (m_rvalid && i_rready)
               state_nxt = IDLE;
         end
         D_AR: begin
            grant     = 2'b10;
            m_araddr  = d_araddr;
            m_arvalid = d_arvalid;
            d_arready = m_arready;
            if (d_arvalid && m_arready)
               state_nxt = D_R;
         end
         D_R: begin
            grant    = 2'b10;
            d_rdata  = m_rdata;
            d_rvalid = m_rvalid;
            m_rready = d_rready;
            if (m_rvalid && d_rready)
               state_nxt = IDLE;
         end
         D_WR: begin
            grant     = 2'b11;
            m_awaddr  = d_awaddr;
            m_awvalid = d_awvalid & ~aw_done;
            d_awready = m_awready & ~aw_done;
            m_wdata   = d_wdata;
            m_wstrb   = d_wstrb;
            m_wvalid  = d_wvalid & ~w_done;
            d_wready  = m_wready & ~w_done;
            aw_fin    = aw_done | (d_awvalid & m_awready);
            w_fin     = w_done | (d_wvalid & m_wready);
            if (aw_fin && w_fin) begin
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
               state_nxt   = D_B;
            end else begin
               aw_done_nxt = aw_fin;
               w_done_nxt  = w_fin;
            end
         end
         D_B: begin
            grant    = 2'b11;
            d_bresp  = m_bresp;
            d_bvalid = m_bvalid;
            m_bready = d_bready;
            if (m_bvalid && d_bready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
